vend_coin_sched: RTL and testbench
==================================

Name: vend_coin_sched

Overview:
- Multi-slot coin front-end controller for the vending FSM.
- Arbitrates round-robin between N_SLOTS coin acceptors and forwards at most one coin per cycle on a single registered coin bus.
- Rejects invalid coin values.
- Enforces a post-dispense lockout so the downstream FSM never sees a coin while the item is being delivered.
- Sits between the acceptor interfaces and the vending FSM. Consumes the FSM's dispense output.

Parameters:
- N_SLOTS, 4: number of coin acceptor slots (2..8).
- HOLD_CYCLES, 3: lockout length in cycles after dispense (>=1).
- CNT_W, 16: width of the vend counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  accept enable; 0 = no new grants.
- slot_req  in  N_SLOTS  per-slot coin request, held until acked.
- slot_coin  in  N_SLOTS*5  per-slot coin value; slot i occupies bits [5i+4:5i].
- slot_ack  out  N_SLOTS  one-hot, one-cycle pulse: the slot's coin was consumed.
- slot_rej  out  1  with slot_ack: the consumed coin was invalid.
- coin_out  out  5  coin to the vending FSM; 0 when idle.
- dispense_in  in  1  dispense from the vending FSM, combinational on coin_out.
- vend_count  out  CNT_W  saturating count of dispenses.
- reject_count  out  8  saturating count of rejected coins.
- busy  out  1  high in LOCK state.

Behaviour:
- Reset values:
  - state = DIS; the first edge after reset releases to ACC if en=1.
  - coin_out = 0, slot_ack = 0, slot_rej = 0.
  - vend_count = 0, reject_count = 0, busy = 0.
  - RR pointer = 0, so slot 0 has highest priority.
- States: DIS (disabled), ACC (accepting), LOCK (lockout).
- Transitions:
  - DIS -> ACC when en=1.
  - ACC -> DIS when en=0; no grant is issued at that edge.
  - ACC -> LOCK when dispense_in=1.
  - LOCK -> (en ? ACC : DIS) when lock counter reaches HOLD_CYCLES-1.
  - LOCK always runs to completion, regardless of en.
- Grant:
  - In ACC with en=1 and dispense_in=0, the RR arbiter picks among eligible slots.
  - A slot is eligible when slot_req=1 and slot_ack for that slot is 0 in the current cycle.
  - At the edge:
    - coin_out <= granted value if it is 5 or 10, else 0.
    - slot_ack[g] <= 1.
    - slot_rej <= 1 if the value is invalid.
    - The pointer advances to g+1 mod N_SLOTS.
- Latency: a request sampled at edge k gives coin_out and ack valid in cycle k..k+1, i.e. one cycle.
- No grant in a cycle:
  - coin_out <= 0, slot_ack <= 0.
  - The pointer is unchanged.
- Requester rule: on the edge ending its ack cycle, the requester drops slot_req or presents a new coin.
- Dispense:
  - dispense_in is sampled only in ACC.
  - dispense_in=1 takes priority over pending requests: no grant at that edge, enter LOCK, lock counter = 0.
  - vend_count increments, saturating at all-ones.
- LOCK:
  - coin_out = 0, no acks, busy = 1.
  - Lock counter increments each cycle.
- Invalid coin: coin_out = 0 and reject_count increments, saturating at 255. It never reaches the FSM.
- dispense_in outside ACC is ignored and not counted.
- rst mid-operation: returns to reset values next edge. Pending requests are not acked. Counters clear.

Decomposition:
- Package vend_pkg:
  - COIN_W = 5, COIN_5 = 5, COIN_10 = 10.
  - sched_state_t enum {DIS, ACC, LOCK}.
  - Function coin_valid().
- Sub-module vend_rr_arb:
  - N-way round-robin arbiter.
  - Inputs: req vector, pointer. Output: one-hot grant plus index.
  - Combinational.
- The pointer, lock counter, FSM and counters live in vend_coin_sched.

Test Plan:
- Reset, en=1, slot_req[0]=1, coin 5, dropped after ack:
  - Cycle after the sampling edge: coin_out=5, slot_ack=0001, slot_rej=0.
  - Next cycle: coin_out=0.
- Slots 0..3 all request continuously, coin 10:
  - Acks in order 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
  - No slot is acked twice in a row.
- Fairness under one persistent requester:
  - Slot 2 holds req continuously; slot 1 raises req once.
  - Slot 1 is acked within 2 cycles.
- Dispense and lockout (stubbed FSM):
  - Coins 5 then 10 cause dispense_in=1 on the 10 cycle.
  - Next 3 cycles: busy=1, coin_out=0, no acks despite pending requests.
  - Then acks resume; vend_count=1.
- Invalid coin 7 on slot 3:
  - slot_ack=1000, slot_rej=1, coin_out=0, reject_count=1.
  - 256 further invalid coins: reject_count saturates at 255.
- Mode changes and reset:
  - en=0 while requests are pending: no acks, state DIS; en=1 resumes.
  - rst asserted during LOCK: all outputs return to reset values the next cycle; vend_count=0.

Source files
------------

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared coin constants, scheduler state type and coin validity check
package vend_pkg;

    localparam int COIN_W = 5;
    localparam logic [COIN_W-1:0] COIN_5  = 5'd5;
    localparam logic [COIN_W-1:0] COIN_10 = 5'd10;

    typedef enum logic [1:0] {
        DIS  = 2'd0,
        ACC  = 2'd1,
        LOCK = 2'd2
    } sched_state_t;

    function automatic logic coin_valid(input logic [COIN_W-1:0] c);
        return (c == COIN_5) || (c == COIN_10);
    endfunction

endpackage

// File: rtl/vend_rr_arb.sv
// rtl/vend_rr_arb.sv - combinational N-way round-robin arbiter, search starts at ptr
module vend_rr_arb #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        cand  = '0;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N);
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/vend_coin_sched.sv
// rtl/vend_coin_sched.sv - round-robin coin front-end with invalid-coin rejection and post-dispense lockout
module vend_coin_sched
    import vend_pkg::*;
#(
    parameter int N_SLOTS     = 4,
    parameter int HOLD_CYCLES = 3,
    parameter int CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [N_SLOTS-1:0]          slot_req,
    input  logic [N_SLOTS*COIN_W-1:0]   slot_coin,
    output logic [N_SLOTS-1:0]          slot_ack,
    output logic                        slot_rej,
    output logic [COIN_W-1:0]           coin_out,
    input  logic                        dispense_in,
    output logic [CNT_W-1:0]            vend_count,
    output logic [7:0]                  reject_count,
    output logic                        busy
);

    localparam int PTR_W = $clog2(N_SLOTS);
    localparam int LCK_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    sched_state_t       state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [LCK_W-1:0]   lock_q, lock_d;
    logic [COIN_W-1:0]  coin_q, coin_d;
    logic [N_SLOTS-1:0] ack_q, ack_d;
    logic               rej_q, rej_d;
    logic [CNT_W-1:0]   vend_q, vend_d;
    logic [7:0]         rejc_q, rejc_d;

    logic [N_SLOTS-1:0] eligible;
    logic [N_SLOTS-1:0] gnt;
    logic [PTR_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic [COIN_W-1:0]  gnt_coin;

    // A slot in its ack cycle still holds req; masking it avoids a double grant.
    assign eligible = slot_req & ~ack_q;
    assign gnt_coin = slot_coin[int'(gnt_idx)*COIN_W +: COIN_W];

    vend_rr_arb #(.N(N_SLOTS), .IDX_W(PTR_W)) u_arb (
        .req   (eligible),
        .ptr   (ptr_q),
        .gnt   (gnt),
        .idx   (gnt_idx),
        .valid (gnt_valid)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        coin_d  = '0;
        ack_d   = '0;
        rej_d   = 1'b0;
        vend_d  = vend_q;
        rejc_d  = rejc_q;
        case (state_q)
            DIS: begin
                if (en) state_d = ACC;
            end
            ACC: begin
                // A dispense must always start its lockout, even if en drops in the same cycle.
                if (dispense_in) begin
                    state_d = LOCK;
                    lock_d  = '0;
                    if (vend_q != '1) vend_d = vend_q + CNT_W'(1);
                end else if (!en) begin
                    state_d = DIS;
                end else if (gnt_valid) begin
                    ack_d = gnt;
                    if (coin_valid(gnt_coin)) begin
                        coin_d = gnt_coin;
                    end else begin
                        rej_d = 1'b1;
                        if (rejc_q != 8'hFF) rejc_d = rejc_q + 8'd1;
                    end
                    ptr_d = (gnt_idx == PTR_W'(N_SLOTS - 1)) ? '0 : gnt_idx + PTR_W'(1);
                end
            end
            LOCK: begin
                if (lock_q == LCK_W'(HOLD_CYCLES - 1)) state_d = en ? ACC : DIS;
                else                                   lock_d  = lock_q + LCK_W'(1);
            end
            default: state_d = DIS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIS;
            ptr_q   <= '0;
            lock_q  <= '0;
            coin_q  <= '0;
            ack_q   <= '0;
            rej_q   <= 1'b0;
            vend_q  <= '0;
            rejc_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
            coin_q  <= coin_d;
            ack_q   <= ack_d;
            rej_q   <= rej_d;
            vend_q  <= vend_d;
            rejc_q  <= rejc_d;
        end
    end

    assign slot_ack     = ack_q;
    assign slot_rej     = rej_q;
    assign coin_out     = coin_q;
    assign vend_count   = vend_q;
    assign reject_count = rejc_q;
    assign busy         = (state_q == LOCK);

endmodule

// File: tb/tb_vend_coin_sched.sv
// tb/tb_vend_coin_sched.sv - directed scoreboard bench for vend_coin_sched with a stubbed vending FSM
module tb_vend_coin_sched;

    typedef struct packed {
        logic [3:0] ack;
        logic       rej;
        logic [4:0] coin;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  slot_req;
    logic [19:0] slot_coin;
    logic [3:0]  slot_ack;
    logic        slot_rej;
    logic [4:0]  coin_out;
    logic        dispense_in;
    logic [15:0] vend_count;
    logic [7:0]  reject_count;
    logic        busy;

    logic [3:0]  oneshot;
    logic        stub_en;
    logic        dispense_force;
    int          credit;
    int          checks;
    int          errors;
    exp_t        sb[$];

    vend_coin_sched #(.N_SLOTS(4), .HOLD_CYCLES(3), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .slot_req     (slot_req),
        .slot_coin    (slot_coin),
        .slot_ack     (slot_ack),
        .slot_rej     (slot_rej),
        .coin_out     (coin_out),
        .dispense_in  (dispense_in),
        .vend_count   (vend_count),
        .reject_count (reject_count),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub vending FSM: dispenses as soon as accumulated credit reaches 15.
    always_comb begin
        dispense_in = dispense_force;
        if (stub_en && coin_out != 5'd0 && (credit + int'(coin_out)) >= 15) dispense_in = 1'b1;
    end

    always @(posedge clk) begin
        if (rst || !stub_en || dispense_in) credit <= 0;
        else                                credit <= credit + int'(coin_out);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (slot_ack !== 4'b0000) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected_ack: observed %b expected none", slot_ack);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_ack",  32'(slot_ack), 32'(e.ack));
                check("sb_rej",  32'(slot_rej), 32'(e.rej));
                check("sb_coin", 32'(coin_out), 32'(e.coin));
            end
        end
    end

    task automatic push_exp(input logic [3:0] ack, input logic rej, input logic [4:0] coin);
        exp_t e;
        e.ack  = ack;
        e.rej  = rej;
        e.coin = coin;
        sb.push_back(e);
    endtask

    task automatic set_coin(input int i, input logic [4:0] v);
        slot_coin[5*i +: 5] = v;
    endtask

    // Requester rule: a one-shot slot drops req on the edge that ends its ack cycle.
    task automatic tick();
        logic [3:0] a;
        a = slot_ack;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (a[i] && oneshot[i]) slot_req[i] = 1'b0;
    endtask

    task automatic do_reset();
        slot_req = '0;
        oneshot  = '0;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_coin"},  32'(coin_out),     32'd0);
        check({tag, "_ack"},   32'(slot_ack),     32'd0);
        check({tag, "_rej"},   32'(slot_rej),     32'd0);
        check({tag, "_vend"},  32'(vend_count),   32'd0);
        check({tag, "_rejc"},  32'(reject_count), 32'd0);
        check({tag, "_busy"},  32'(busy),         32'd0);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        en             = 1'b0;
        slot_req       = '0;
        slot_coin      = '0;
        oneshot        = '0;
        stub_en        = 1'b0;
        dispense_force = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");

        // Single coin 5 on slot 0, one-cycle latency then idle.
        rst = 1'b0;
        en  = 1'b1;
        tick();
        set_coin(0, 5'd5);
        oneshot[0]  = 1'b1;
        slot_req[0] = 1'b1;
        push_exp(4'b0001, 1'b0, 5'd5);
        tick();
        check("single_coin", 32'(coin_out), 32'd5);
        check("single_ack",  32'(slot_ack), 32'b0001);
        check("single_rej",  32'(slot_rej), 32'd0);
        tick();
        check("single_idle_coin", 32'(coin_out), 32'd0);
        check("single_idle_ack",  32'(slot_ack), 32'd0);

        // All four slots requesting continuously: strict rotation.
        do_reset();
        for (int i = 0; i < 4; i++) set_coin(i, 5'd10);
        slot_req = 4'b1111;
        push_exp(4'b0001, 1'b0, 5'd10);
        push_exp(4'b0010, 1'b0, 5'd10);
        push_exp(4'b0100, 1'b0, 5'd10);
        push_exp(4'b1000, 1'b0, 5'd10);
        push_exp(4'b0001, 1'b0, 5'd10);
        for (int k = 0; k < 5; k++) tick();
        slot_req = '0;
        tick();
        check("rr_drained", 32'(sb.size()), 32'd0);

        // Fairness: slot 2 persistent, slot 1 raised once (pointer is at 1).
        set_coin(2, 5'd10);
        slot_req[2] = 1'b1;
        push_exp(4'b0100, 1'b0, 5'd10);
        tick();
        set_coin(1, 5'd5);
        oneshot[1]  = 1'b1;
        slot_req[1] = 1'b1;
        push_exp(4'b0010, 1'b0, 5'd5);
        push_exp(4'b0100, 1'b0, 5'd10);
        tick();
        check("fair_slot1", 32'(slot_ack), 32'b0010);
        tick();
        slot_req[2] = 1'b0;
        tick();
        tick();
        check("fair_drained", 32'(sb.size()), 32'd0);

        // Dispense on the 10 coin, three lockout cycles, then pending acks resume.
        do_reset();
        stub_en = 1'b1;
        set_coin(0, 5'd5);
        oneshot[0]  = 1'b1;
        slot_req[0] = 1'b1;
        push_exp(4'b0001, 1'b0, 5'd5);
        tick();
        set_coin(1, 5'd10);
        oneshot[1]  = 1'b1;
        slot_req[1] = 1'b1;
        push_exp(4'b0010, 1'b0, 5'd10);
        tick();
        set_coin(2, 5'd5);
        set_coin(3, 5'd5);
        oneshot[3:2]  = 2'b11;
        slot_req[3:2] = 2'b11;
        push_exp(4'b0100, 1'b0, 5'd5);
        push_exp(4'b1000, 1'b0, 5'd5);
        tick();
        check("lock_vend", 32'(vend_count), 32'd1);
        for (int k = 0; k < 3; k++) begin
            check("lock_busy", 32'(busy),     32'd1);
            check("lock_coin", 32'(coin_out), 32'd0);
            check("lock_ack",  32'(slot_ack), 32'd0);
            tick();
        end
        check("lock_released", 32'(busy), 32'd0);
        tick();
        check("lock_resume_ack", 32'(slot_ack), 32'b0100);
        tick();
        tick();
        tick();
        check("lock_drained", 32'(sb.size()), 32'd0);
        check("lock_vend_end", 32'(vend_count), 32'd1);
        stub_en = 1'b0;

        // Invalid coin 7 on slot 3, then saturation of the reject counter.
        set_coin(3, 5'd7);
        oneshot[3]  = 1'b1;
        slot_req[3] = 1'b1;
        push_exp(4'b1000, 1'b1, 5'd0);
        tick();
        check("inv_rej",   32'(slot_rej),     32'd1);
        check("inv_coin",  32'(coin_out),     32'd0);
        check("inv_count", 32'(reject_count), 32'd1);
        oneshot = '0;
        for (int i = 0; i < 4; i++) set_coin(i, 5'd7);
        slot_req = 4'b1111;
        for (int k = 0; k < 256; k++) push_exp(4'(1 << (k % 4)), 1'b1, 5'd0);
        for (int k = 0; k < 256; k++) tick();
        slot_req = '0;
        tick();
        tick();
        check("inv_saturate", 32'(reject_count), 32'd255);
        check("inv_drained",  32'(sb.size()),    32'd0);

        // en=0 with a pending request: nothing granted, stray dispense ignored.
        en = 1'b0;
        set_coin(0, 5'd5);
        oneshot[0]  = 1'b1;
        slot_req[0] = 1'b1;
        tick();
        check("dis_ack",  32'(slot_ack), 32'd0);
        check("dis_coin", 32'(coin_out), 32'd0);
        dispense_force = 1'b1;
        tick();
        dispense_force = 1'b0;
        check("dis_ack2",         32'(slot_ack),   32'd0);
        check("dis_busy",         32'(busy),       32'd0);
        check("dis_vend_ignored", 32'(vend_count), 32'd1);
        en = 1'b1;
        push_exp(4'b0001, 1'b0, 5'd5);
        tick();
        check("en_wake_no_ack", 32'(slot_ack), 32'd0);
        tick();
        check("en_resume_ack", 32'(slot_ack), 32'b0001);
        tick();

        // Reset in the middle of a lockout with a request pending.
        dispense_force = 1'b1;
        tick();
        dispense_force = 1'b0;
        check("rstlock_busy", 32'(busy),       32'd1);
        check("rstlock_vend", 32'(vend_count), 32'd2);
        set_coin(1, 5'd10);
        slot_req[1] = 1'b1;
        rst = 1'b1;
        tick();
        check_reset_outputs("rstlock");
        tick();
        check("rstlock_no_ack", 32'(slot_ack), 32'd0);
        slot_req = '0;
        rst      = 1'b0;
        tick();
        tick();
        check("final_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
